// File: rtl/mul_sequencer.sv
// Multiply-instruction sequencer: reads operands over one RF read port, issues one
// multiplier request, writes back one or two words and optionally N/Z flags.
module mul_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_long,
    input  logic        i_sign,
    input  logic        i_acc,
    input  logic        i_setf,
    input  logic [3:0]  i_rd,
    input  logic [3:0]  i_rn,
    input  logic [3:0]  i_rs,
    input  logic [3:0]  i_rm,
    output logic [3:0]  o_rf_raddr,
    input  logic [31:0] i_rf_rdata,
    output logic        o_rf_we,
    output logic [3:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_mul_vld,
    output logic        o_mul_sign,
    output logic [31:0] o_mul_op1,
    output logic [31:0] o_mul_op2,
    output logic [63:0] o_mul_acc,
    input  logic [63:0] i_mul_result,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_flag_vld,
    output logic        o_flag_n,
    output logic        o_flag_z
);

    typedef enum logic [3:0] {
        IDLE, RD_M, RD_S, RD_A0, RD_A1, ISSUE, EXEC, WB_LO, WB_HI
    } state_t;

    state_t      state;
    logic        long_r, sign_r, acc_r, setf_r;
    logic [3:0]  rd_r, rn_r, rs_r;
    logic [31:0] op1_r, op2_r, acc_lo_r, hi_r;
    logic        we_q, vld_q, done_q, flag_vld_q, flag_n_q, flag_z_q;

    // Write-enable style outputs are registered, then killed combinationally by a flush.
    assign o_rf_we    = we_q & ~i_flush;
    assign o_mul_vld  = vld_q & ~i_flush;
    assign o_done     = done_q & ~i_flush;
    assign o_flag_vld = flag_vld_q & ~i_flush;

    // Low-word data and short-op flags exist only while the multiplier result is on the bus.
    always_comb begin
        o_rf_wdata = '0;
        o_flag_n   = flag_n_q;
        o_flag_z   = flag_z_q;
        if (state == WB_LO) begin
            o_rf_wdata = i_mul_result[31:0];
            if (!long_r) begin
                o_flag_n = i_mul_result[31];
                o_flag_z = (i_mul_result[31:0] == 32'd0);
            end
        end else if (state == WB_HI) begin
            o_rf_wdata = hi_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            long_r     <= 1'b0;
            sign_r     <= 1'b0;
            acc_r      <= 1'b0;
            setf_r     <= 1'b0;
            rd_r       <= '0;
            rn_r       <= '0;
            rs_r       <= '0;
            op1_r      <= '0;
            op2_r      <= '0;
            acc_lo_r   <= '0;
            hi_r       <= '0;
            o_rf_raddr <= '0;
            o_rf_waddr <= '0;
            o_mul_sign <= 1'b0;
            o_mul_op1  <= '0;
            o_mul_op2  <= '0;
            o_mul_acc  <= '0;
            o_busy     <= 1'b0;
            we_q       <= 1'b0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            flag_vld_q <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_z_q   <= 1'b0;
        end else begin
            o_rf_raddr <= '0;
            o_rf_waddr <= '0;
            we_q       <= 1'b0;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            flag_vld_q <= 1'b0;
            if (i_flush) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (i_start) begin
                        long_r     <= i_long;
                        sign_r     <= i_long & i_sign;
                        acc_r      <= i_acc;
                        setf_r     <= i_setf;
                        rd_r       <= i_rd;
                        rn_r       <= i_rn;
                        rs_r       <= i_rs;
                        o_rf_raddr <= i_rm;
                        o_busy     <= 1'b1;
                        state      <= RD_M;
                    end
                    RD_M: begin
                        o_rf_raddr <= rs_r;
                        state      <= RD_S;
                    end
                    RD_S: begin
                        op1_r <= i_rf_rdata;
                        if (acc_r) begin
                            // Rn and RdLo share the i_rn field, so both accumulate kinds read it here.
                            o_rf_raddr <= rn_r;
                            state      <= RD_A0;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                    RD_A0: begin
                        op2_r <= i_rf_rdata;
                        if (long_r) begin
                            o_rf_raddr <= rd_r;
                            state      <= RD_A1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                    RD_A1: begin
                        acc_lo_r <= i_rf_rdata;
                        state    <= ISSUE;
                    end
                    ISSUE: begin
                        o_mul_op1  <= op1_r;
                        o_mul_op2  <= acc_r ? op2_r : i_rf_rdata;
                        o_mul_sign <= sign_r;
                        if (!acc_r)
                            o_mul_acc <= '0;
                        else if (long_r)
                            o_mul_acc <= {i_rf_rdata, acc_lo_r};
                        else
                            o_mul_acc <= {32'd0, i_rf_rdata};
                        vld_q <= 1'b1;
                        state <= EXEC;
                    end
                    EXEC: begin
                        we_q       <= 1'b1;
                        o_rf_waddr <= long_r ? rn_r : rd_r;
                        done_q     <= ~long_r;
                        flag_vld_q <= ~long_r & setf_r;
                        state      <= WB_LO;
                    end
                    WB_LO: begin
                        hi_r <= i_mul_result[63:32];
                        if (long_r) begin
                            flag_n_q   <= i_mul_result[63];
                            flag_z_q   <= (i_mul_result == 64'd0);
                            we_q       <= 1'b1;
                            o_rf_waddr <= rd_r;
                            done_q     <= 1'b1;
                            flag_vld_q <= setf_r;
                            state      <= WB_HI;
                        end else begin
                            flag_n_q <= i_mul_result[31];
                            flag_z_q <= (i_mul_result[31:0] == 32'd0);
                            o_busy   <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    WB_HI: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a register-file and multiplier model.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0, i_long = 1'b0, i_sign = 1'b0, i_acc = 1'b0, i_setf = 1'b0;
    logic [3:0]  i_rd = '0, i_rn = '0, i_rs = '0, i_rm = '0;
    logic [3:0]  o_rf_raddr;
    logic [31:0] i_rf_rdata = '0;
    logic        o_rf_we;
    logic [3:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_mul_vld, o_mul_sign;
    logic [31:0] o_mul_op1, o_mul_op2;
    logic [63:0] o_mul_acc;
    logic [63:0] i_mul_result = '0;
    logic        i_flush = 1'b0;
    logic        o_busy, o_done, o_flag_vld, o_flag_n, o_flag_z;

    mul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_long(i_long), .i_sign(i_sign),
        .i_acc(i_acc), .i_setf(i_setf), .i_rd(i_rd), .i_rn(i_rn), .i_rs(i_rs), .i_rm(i_rm),
        .o_rf_raddr(o_rf_raddr), .i_rf_rdata(i_rf_rdata), .o_rf_we(o_rf_we),
        .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata), .o_mul_vld(o_mul_vld),
        .o_mul_sign(o_mul_sign), .o_mul_op1(o_mul_op1), .o_mul_op2(o_mul_op2),
        .o_mul_acc(o_mul_acc), .i_mul_result(i_mul_result), .i_flush(i_flush),
        .o_busy(o_busy), .o_done(o_done), .o_flag_vld(o_flag_vld),
        .o_flag_n(o_flag_n), .o_flag_z(o_flag_z)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    logic [31:0] rf [16];

    // One-cycle read latency register file; writes are observed via the log only.
    always @(posedge clk) i_rf_rdata <= rf[o_rf_raddr];

    always @(posedge clk) begin
        logic [63:0] a, b;
        if (o_mul_vld) begin
            a = o_mul_sign ? {{32{o_mul_op1[31]}}, o_mul_op1} : {32'd0, o_mul_op1};
            b = o_mul_sign ? {{32{o_mul_op2[31]}}, o_mul_op2} : {32'd0, o_mul_op2};
            i_mul_result <= a * b + o_mul_acc;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    int          done_c, nvld;
    logic        fv, fn, fz, x_sign;
    logic [31:0] x_op1, x_op2;
    logic [63:0] x_acc;

    always @(negedge clk) begin
        if (o_rf_we) begin
            wr_addr.push_back(o_rf_waddr);
            wr_data.push_back(o_rf_wdata);
            wr_cyc.push_back(cyc - t0);
        end
        if (o_done) done_c = cyc - t0;
        if (o_flag_vld) begin
            fv = 1'b1;
            fn = o_flag_n;
            fz = o_flag_z;
        end
        if (o_mul_vld) begin
            nvld++;
            x_op1  = o_mul_op1;
            x_op2  = o_mul_op2;
            x_acc  = o_mul_acc;
            x_sign = o_mul_sign;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_c = -1;
        nvld   = 0;
        fv = 1'b0; fn = 1'b0; fz = 1'b0;
        x_op1 = '0; x_op2 = '0; x_acc = '0; x_sign = 1'b0;
    endtask

    // Called just after a rising edge; drives one command and leaves the bench in cycle 1.
    task automatic start_cmd(input logic lng, input logic sgn, input logic acc, input logic setf,
                             input logic [3:0] rd, input logic [3:0] rn,
                             input logic [3:0] rs, input logic [3:0] rm);
        clear_log();
        i_long = lng; i_sign = sgn; i_acc = acc; i_setf = setf;
        i_rd = rd; i_rn = rn; i_rs = rs; i_rm = rm;
        t0 = cyc;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_c1", 64'(o_busy), 64'd1);
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_zero"}, {o_rf_raddr, o_rf_waddr, o_rf_we, o_mul_vld, o_mul_sign,
                             o_busy, o_done, o_flag_vld, o_flag_n, o_flag_z}, 64'd0);
        chk({tag, "_ops"}, {o_mul_op1, o_mul_op2}, 64'd0);
        chk({tag, "_acc"}, o_mul_acc, 64'd0);
        chk({tag, "_wdata"}, 64'(o_rf_wdata), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MUL R2 = R0*R1, 7*6
        rf[0] = 32'd7; rf[1] = 32'd6;
        start_cmd(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd9, 4'd1, 4'd0);
        settle();
        chk("mul_op1", 64'(x_op1), 64'd7);
        chk("mul_op2", 64'(x_op2), 64'd6);
        chk("mul_acc", x_acc, 64'd0);
        chk("mul_nwr", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            chk("mul_waddr", 64'(wr_addr[0]), 64'd2);
            chk("mul_wdata", 64'(wr_data[0]), 64'd42);
            chk("mul_wcyc", 64'(wr_cyc[0]), 64'd5);
        end
        chk("mul_done", 64'(done_c), 64'd5);
        chk("mul_flags", {61'd0, fv, fn, fz}, 64'b100);
        chk("mul_idle", 64'(o_busy), 64'd0);

        // MLA R3 = R0*R1 + R4
        rf[0] = 32'hFFFF_FFFF; rf[1] = 32'd2; rf[4] = 32'd3;
        start_cmd(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd4, 4'd1, 4'd0);
        settle();
        chk("mla_acc", x_acc, 64'h0000_0000_0000_0003);
        chk("mla_sign", 64'(x_sign), 64'd0);
        chk("mla_nwr", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            chk("mla_waddr", 64'(wr_addr[0]), 64'd3);
            chk("mla_wdata", 64'(wr_data[0]), 64'd1);
            chk("mla_wcyc", 64'(wr_cyc[0]), 64'd6);
        end
        chk("mla_noflag", 64'(fv), 64'd0);

        // SMULL {R5,R4} = -2 * 3
        rf[0] = 32'hFFFF_FFFE; rf[1] = 32'd3;
        start_cmd(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 4'd4, 4'd1, 4'd0);
        settle();
        chk("smull_sign", 64'(x_sign), 64'd1);
        chk("smull_acc", x_acc, 64'd0);
        chk("smull_nwr", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            chk("smull_lo", {28'd0, wr_addr[0], wr_data[0]}, {28'd0, 4'd4, 32'hFFFF_FFFA});
            chk("smull_lo_cyc", 64'(wr_cyc[0]), 64'd5);
            chk("smull_hi", {28'd0, wr_addr[1], wr_data[1]}, {28'd0, 4'd5, 32'hFFFF_FFFF});
            chk("smull_hi_cyc", 64'(wr_cyc[1]), 64'd6);
        end
        chk("smull_done", 64'(done_c), 64'd6);
        chk("smull_flags", {61'd0, fv, fn, fz}, 64'b110);

        // UMLAL {R7,R6} += R0*R1 with RdHi=1, RdLo=0xFFFFFFFF, 1*1
        rf[0] = 32'd1; rf[1] = 32'd1; rf[6] = 32'hFFFF_FFFF; rf[7] = 32'd1;
        start_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 4'd6, 4'd1, 4'd0);
        settle();
        chk("umlal_acc", x_acc, 64'h0000_0001_FFFF_FFFF);
        chk("umlal_nwr", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            chk("umlal_lo", {28'd0, wr_addr[0], wr_data[0]}, {28'd0, 4'd6, 32'd0});
            chk("umlal_lo_cyc", 64'(wr_cyc[0]), 64'd7);
            chk("umlal_hi", {28'd0, wr_addr[1], wr_data[1]}, {28'd0, 4'd7, 32'd2});
            chk("umlal_hi_cyc", 64'(wr_cyc[1]), 64'd8);
        end
        chk("umlal_done", 64'(done_c), 64'd8);
        chk("umlal_flags", {61'd0, fv, fn, fz}, 64'b100);

        // Flush in EXEC (cycle 4) of a UMULL
        rf[0] = 32'd5; rf[1] = 32'd9;
        start_cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd8, 4'd1, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        i_flush = 1'b1;
        #1;
        chk("flush_vld", 64'(o_mul_vld), 64'd0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush_busy", 64'(o_busy), 64'd0);
        chk("flush_nwr", 64'(wr_addr.size()), 64'd0);
        chk("flush_nvld", 64'(nvld), 64'd0);
        rf[0] = 32'd3; rf[1] = 32'd4;
        start_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 4'd1, 4'd0);
        settle();
        chk("postflush_nwr", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            chk("postflush_wr", {28'd0, wr_addr[0], wr_data[0]}, {28'd0, 4'd2, 32'd12});
            chk("postflush_cyc", 64'(wr_cyc[0]), 64'd5);
        end

        // Flush in IDLE blocks a simultaneous start
        clear_log();
        t0 = cyc;
        i_start = 1'b1; i_flush = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_flush = 1'b0;
        chk("idleflush_busy", 64'(o_busy), 64'd0);
        settle();
        chk("idleflush_nwr", 64'(wr_addr.size()), 64'd0);

        // Async reset during RD_A1 (cycle 4) of a UMLAL
        start_cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 4'd6, 4'd1, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        chk("midrst_nwr", 64'(wr_addr.size()), 64'd0);
        chk("midrst_nvld", 64'(nvld), 64'd0);
        rf[0] = 32'd11; rf[1] = 32'd3;
        start_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd1, 4'd0);
        settle();
        chk("postrst_nwr", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1)
            chk("postrst_wr", {28'd0, wr_addr[0], wr_data[0]}, {28'd0, 4'd5, 32'd33});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
